// File: rtl/stat_dump_uart.sv
// rtl/stat_dump_uart.sv - snapshots five statistics words and sends them as a checksummed 8N1 UART frame
module stat_dump_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        dump,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] SyscallOut,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  LAST_BYTE = 5'd21;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    state_t         state;
    logic           halt_d;
    logic [159:0]   snap;
    logic [7:0]     shifter;
    logic [7:0]     checksum;
    logic [15:0]    bit_cnt;
    logic [2:0]     bit_idx;
    logic [4:0]     byte_idx;

    logic           trigger;
    logic           bit_end;
    logic           next_is_crc;
    logic [7:0]     next_byte;

    assign trigger     = dump | (halt & ~halt_d);
    assign bit_end     = (bit_cnt == BIT_LAST);
    // The snapshot is consumed from its top byte, so the head is always the next data byte.
    assign next_is_crc = (byte_idx == LAST_BYTE - 5'd1);
    assign next_byte   = next_is_crc ? checksum : snap[159:152];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            halt_d   <= 1'b0;
            snap     <= '0;
            shifter  <= '0;
            checksum <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            halt_d <= halt;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        snap     <= {total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut};
                        shifter  <= SYNC_BYTE;
                        checksum <= '0;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shifter[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shifter[1];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            shifter  <= next_byte;
                            if (!next_is_crc) begin
                                checksum <= checksum ^ snap[159:152];
                                snap     <= {snap[151:0], 8'h00};
                            end
                            tx    <= 1'b0;
                            state <= START;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_dump_uart.sv
// tb/tb_stat_dump_uart.sv - randomized self-checking bench for stat_dump_uart against a frame-level model
module tb_stat_dump_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        dump = 1'b0;
    logic [31:0] total_cycles = '0;
    logic [31:0] uncondi_num = '0;
    logic [31:0] condi_num = '0;
    logic [31:0] condi_suc_num = '0;
    logic [31:0] SyscallOut = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    stat_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .halt(halt), .dump(dump),
        .total_cycles(total_cycles), .uncondi_num(uncondi_num), .condi_num(condi_num),
        .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Line receiver: samples each bit at its centre, independent of the DUT internals.
    logic [7:0] rx_q[$];
    int         rx_cnt = 0;
    bit         rx_act = 0;
    logic [7:0] rx_sh = '0;
    int         frame_err = 0;
    int         busy_cycles = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 0;
        end else begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (!rx_act) begin
                if (tx == 1'b0) begin
                    rx_act = 1;
                    rx_cnt = 1;
                end
            end else begin
                if (rx_cnt % CPB == CPB / 2) begin
                    if (rx_cnt / CPB == 0) begin
                        if (tx !== 1'b0) frame_err++;
                    end else if (rx_cnt / CPB <= 8) begin
                        rx_sh[rx_cnt / CPB - 1] = tx;
                    end else begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(rx_sh);
                        rx_act = 0;
                    end
                end
                rx_cnt++;
            end
        end
    end

    logic [7:0] exp_q[$];

    function automatic void model_frame(input logic [31:0] w0, w1, w2, w3, w4);
        logic [31:0] w[5];
        logic [7:0]  cs;
        w = '{w0, w1, w2, w3, w4};
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'((w[i] >> (8 * b)) & 32'hFF));
                cs = cs ^ 8'((w[i] >> (8 * b)) & 32'hFF);
            end
        end
        exp_q.push_back(cs);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [31:0] w0, w1, w2, w3, w4);
        total_cycles = w0; uncondi_num = w1; condi_num = w2; condi_suc_num = w3; SyscallOut = w4;
    endtask

    task automatic pulse_dump();
        dump = 1'b1;
        tick();
        dump = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt <= base && n < 1200) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, 32'(done_cnt > base), 32'd1);
    endtask

    task automatic wait_bytes(input int target, input string tag);
        int n = 0;
        while (rx_q.size() < target && n < 1200) begin
            tick();
            n++;
        end
        check({tag, "_bytes_timeout"}, 32'(rx_q.size() >= target), 32'd1);
    endtask

    task automatic check_frame(input int base, input string tag);
        int bad = 0;
        check({tag, "_size"}, 32'(rx_q.size() - base >= 22), 32'd1);
        if (rx_q.size() - base >= 22) begin
            for (int i = 0; i < 22; i++) begin
                if (rx_q[base + i] !== exp_q[i]) begin
                    if (bad == 0) check({tag, "_byte"}, 32'(rx_q[base + i]), 32'(exp_q[i]));
                    bad++;
                end
            end
            check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        int rb, db, bb;

        // Reset and quiet period
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (100) tick();
        check("idle_no_bytes", 32'(rx_q.size()), 32'd0);
        check("idle_no_busy", 32'(busy_cycles), 32'd0);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // Basic dump
        set_words(32'h10, 32'h2, 32'h3, 32'h1, 32'h12345678);
        model_frame(32'h10, 32'h2, 32'h3, 32'h1, 32'h12345678);
        rb = rx_q.size(); db = done_cnt; bb = busy_cycles;
        pulse_dump();
        check("basic_busy_rise", 32'(busy), 32'd1);
        check("basic_start_bit", 32'(tx), 32'd0);
        wait_done(db, "basic");
        repeat (5) tick();
        check_frame(rb, "basic");
        if (rx_q.size() - rb >= 22) check("basic_crc", 32'(rx_q[rb + 21]), 32'h18);
        check("basic_busy_cycles", 32'(busy_cycles - bb), 32'(220 * CPB));
        check("basic_done_once", 32'(done_cnt - db), 32'd1);

        // Random snapshots
        for (int it = 0; it < 3; it++) begin
            logic [31:0] r0, r1, r2, r3, r4;
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
            set_words(r0, r1, r2, r3, r4);
            model_frame(r0, r1, r2, r3, r4);
            rb = rx_q.size(); db = done_cnt;
            pulse_dump();
            set_words($urandom, $urandom, $urandom, $urandom, $urandom);
            wait_done(db, "rand");
            repeat (3) tick();
            check_frame(rb, "rand");
        end

        // Halt rising edge, snapshot held, no retrigger while high
        set_words(32'hCAFE0001, 32'h0BADF00D, 32'h55AA55AA, 32'h00000007, 32'h80000000);
        model_frame(32'hCAFE0001, 32'h0BADF00D, 32'h55AA55AA, 32'h00000007, 32'h80000000);
        rb = rx_q.size(); db = done_cnt;
        halt = 1'b1;
        tick();
        total_cycles = 32'hFFFFFFFF;
        check("halt_busy", 32'(busy), 32'd1);
        wait_done(db, "halt");
        repeat (300) tick();
        check_frame(rb, "halt");
        check("halt_single_frame", 32'(rx_q.size() - rb), 32'd22);
        check("halt_single_done", 32'(done_cnt - db), 32'd1);
        halt = 1'b0;
        repeat (5) tick();

        // Dump during byte 5 is ignored
        set_words($urandom, $urandom, $urandom, $urandom, $urandom);
        model_frame(total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut);
        rb = rx_q.size(); db = done_cnt;
        pulse_dump();
        wait_bytes(rb + 5, "ign");
        repeat (2 * CPB) tick();
        pulse_dump();
        wait_done(db, "ign");
        repeat (60) tick();
        check_frame(rb, "ign");
        check("ign_byte_count", 32'(rx_q.size() - rb), 32'd22);
        check("ign_done_count", 32'(done_cnt - db), 32'd1);

        // Reset during byte 10
        set_words($urandom, $urandom, $urandom, $urandom, $urandom);
        rb = rx_q.size();
        pulse_dump();
        wait_bytes(rb + 10, "mid");
        repeat (3 * CPB) tick();
        db = done_cnt;
        rst = 1'b1;
        tick();
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("mid_no_done", 32'(done_cnt - db), 32'd0);
        check("mid_quiet", 32'(busy), 32'd0);
        set_words($urandom, $urandom, $urandom, $urandom, $urandom);
        model_frame(total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut);
        rb = rx_q.size(); db = done_cnt;
        pulse_dump();
        wait_done(db, "post_rst");
        repeat (3) tick();
        check_frame(rb, "post_rst");

        // Back-to-back: retrigger on the done cycle
        begin
            logic [7:0] exp_a[$];
            int n;
            set_words($urandom, $urandom, $urandom, $urandom, $urandom);
            model_frame(total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut);
            exp_a = exp_q;
            rb = rx_q.size(); db = done_cnt;
            pulse_dump();
            set_words($urandom, $urandom, $urandom, $urandom, $urandom);
            n = 0;
            while (done !== 1'b1 && n < 1200) begin
                tick();
                n++;
            end
            check("b2b_first_done", 32'(done), 32'd1);
            dump = 1'b1;
            tick();
            dump = 1'b0;
            check("b2b_busy_again", 32'(busy), 32'd1);
            check("b2b_start_bit", 32'(tx), 32'd0);
            wait_done(db + 1, "b2b");
            repeat (5) tick();
            exp_q = exp_a;
            check_frame(rb, "b2b_first");
            model_frame(total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut);
            check_frame(rb + 22, "b2b_second");
            check("b2b_done_count", 32'(done_cnt - db), 32'd2);
        end

        check("framing_errors", 32'(frame_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
